// File: rtl/exec_ctrl_slice.sv
// rtl/exec_ctrl_slice.sv - opcode decoder, add/sub ALU with flags, registered PC incrementer
module exec_ctrl_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             alu_op,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] pc_next,
  output logic             ALU_Op,
  output logic             Reg_Dest,
  output logic             Reg_Write,
  output logic             Jump,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             Mem_to_Reg,
  output logic             imm_flag
);

  logic [7:0]       w_ctrl;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_sa;
  logic             w_sb;
  logic             w_sr;
  logic [WIDTH-1:0] r_pc_next;

  // Strobe row order: ALU_Op, Reg_Dest, Reg_Write, Jump, Mem_Read, Mem_Write, Mem_to_Reg, imm_flag
  always_comb begin
    w_ctrl = 8'b0000_0000;
    case (opcode)
      3'b000:  w_ctrl = 8'b1110_0000;
      3'b001:  w_ctrl = 8'b0110_0000;
      3'b010:  w_ctrl = 8'b1010_0001;
      3'b011:  w_ctrl = 8'b1010_1011;
      3'b100:  w_ctrl = 8'b1000_0101;
      3'b101:  w_ctrl = 8'b0001_0000;
      default: w_ctrl = 8'b0000_0000;
    endcase
  end

  assign {ALU_Op, Reg_Dest, Reg_Write, Jump, Mem_Read, Mem_Write, Mem_to_Reg, imm_flag} = w_ctrl;

  // The extra top bit of the widened difference is the unsigned borrow.
  assign w_sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign w_diff = {1'b0, alu_a} - {1'b0, alu_b};
  assign w_sa   = alu_a[WIDTH-1];
  assign w_sb   = alu_b[WIDTH-1];
  assign w_sr   = alu_out[WIDTH-1];

  always_comb begin
    alu_out  = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    if (alu_op) begin
      alu_out  = w_sum[WIDTH-1:0];
      carry    = w_sum[WIDTH];
      overflow = (w_sa == w_sb) && (w_sr != w_sa);
    end else begin
      alu_out  = w_diff[WIDTH-1:0];
      carry    = w_diff[WIDTH];
      overflow = (w_sa != w_sb) && (w_sr != w_sa);
    end
  end

  assign zero = (alu_out == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc_next <= '0;
    end else begin
      r_pc_next <= pc_in + 1'b1;
    end
  end

  assign pc_next = r_pc_next;

endmodule

// File: tb/tb_exec_ctrl_slice.sv
// tb/tb_exec_ctrl_slice.sv - directed self-checking bench for exec_ctrl_slice
module tb_exec_ctrl_slice;

  logic       clock;
  logic       reset_n;
  logic [2:0] opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_op;
  logic [7:0] pc_in;
  logic [7:0] alu_out;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic [7:0] pc_next;
  logic       ALU_Op, Reg_Dest, Reg_Write, Jump, Mem_Read, Mem_Write, Mem_to_Reg, imm_flag;

  int n_vec;
  int n_bad;

  exec_ctrl_slice #(.WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .pc_in(pc_in), .alu_out(alu_out), .zero(zero), .carry(carry),
    .overflow(overflow), .pc_next(pc_next), .ALU_Op(ALU_Op), .Reg_Dest(Reg_Dest),
    .Reg_Write(Reg_Write), .Jump(Jump), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_to_Reg(Mem_to_Reg), .imm_flag(imm_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_row();
    return {ALU_Op, Reg_Dest, Reg_Write, Jump, Mem_Read, Mem_Write, Mem_to_Reg, imm_flag};
  endfunction

  function automatic logic [10:0] alu_row();
    return {alu_out, zero, carry, overflow};
  endfunction

  task automatic alu_vec(input string tag, input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic z, input logic c, input logic v);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    #1;
    check(tag, {21'd0, alu_row()}, {21'd0, r, z, c, v});
  endtask

  task automatic pc_step(input string tag, input logic rn, input logic [7:0] pc, input logic [7:0] exp);
    reset_n = rn;
    pc_in   = pc;
    @(posedge clock);
    #1;
    check(tag, {24'd0, pc_next}, {24'd0, exp});
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    opcode  = 3'b000;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_op  = 1'b1;
    pc_in   = 8'hF3;

    // Reset first; also check decoder/ALU stay live while reset is held
    @(negedge clock);
    pc_step("pc_reset", 1'b0, 8'hF3, 8'h00);
    opcode = 3'b000;
    alu_vec("alu_during_reset", 1'b1, 8'h21, 8'h04, 8'h25, 1'b0, 1'b0, 1'b0);
    check("dec_during_reset", {24'd0, ctrl_row()}, {24'd0, 8'b1110_0000});
    pc_step("pc_reset_hold", 1'b0, 8'h10, 8'h00);

    // Decoder sweep
    opcode = 3'b000; #1; check("dec_000", {24'd0, ctrl_row()}, {24'd0, 8'b1110_0000});
    opcode = 3'b001; #1; check("dec_001", {24'd0, ctrl_row()}, {24'd0, 8'b0110_0000});
    opcode = 3'b010; #1; check("dec_010", {24'd0, ctrl_row()}, {24'd0, 8'b1010_0001});
    opcode = 3'b011; #1; check("dec_011", {24'd0, ctrl_row()}, {24'd0, 8'b1010_1011});
    opcode = 3'b100; #1; check("dec_100", {24'd0, ctrl_row()}, {24'd0, 8'b1000_0101});
    opcode = 3'b101; #1; check("dec_101", {24'd0, ctrl_row()}, {24'd0, 8'b0001_0000});
    opcode = 3'b110; #1; check("dec_110", {24'd0, ctrl_row()}, {24'd0, 8'b0000_0000});
    opcode = 3'b111; #1; check("dec_111", {24'd0, ctrl_row()}, {24'd0, 8'b0000_0000});

    // ALU add
    alu_vec("add_6d_0c", 1'b1, 8'h6D, 8'h0C, 8'h79, 1'b0, 1'b0, 1'b0);
    alu_vec("add_21_04", 1'b1, 8'h21, 8'h04, 8'h25, 1'b0, 1'b0, 1'b0);
    alu_vec("add_7d_2c", 1'b1, 8'h7D, 8'h2C, 8'hA9, 1'b0, 1'b0, 1'b1);
    alu_vec("add_ff_01", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    alu_vec("add_80_80", 1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);

    // ALU subtract
    alu_vec("sub_01_00", 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    alu_vec("sub_7d_0c", 1'b0, 8'h7D, 8'h0C, 8'h71, 1'b0, 1'b0, 1'b0);
    alu_vec("sub_19_41", 1'b0, 8'h19, 8'h41, 8'hD8, 1'b0, 1'b1, 1'b0);
    alu_vec("sub_80_01", 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    alu_vec("sub_55_55", 1'b0, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0);
    alu_vec("sub_7f_ff", 1'b0, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b1);

    // PC increment, wrap, mid-run reset and recovery
    pc_step("pc_f3", 1'b1, 8'hF3, 8'hF4);
    pc_step("pc_b7", 1'b1, 8'hB7, 8'hB8);
    pc_step("pc_wrap", 1'b1, 8'hFF, 8'h00);
    pc_step("pc_midrst", 1'b0, 8'h21, 8'h00);
    pc_step("pc_release", 1'b1, 8'h21, 8'h22);

    // Reset dropped between edges must not touch pc_next until the edge
    reset_n = 1'b0;
    #2;
    check("pc_sync_hold", {24'd0, pc_next}, {24'd0, 8'h22});
    pc_step("pc_sync_edge", 1'b0, 8'h21, 8'h00);
    pc_step("pc_after", 1'b1, 8'h00, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
